// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory bus between NREQ fetch-side
// requesters (index 0 = icache refill). One single-word read is in flight at
// a time: IDLE picks a winner and grants it, ISSUE drives the bus request for
// one cycle, WAIT routes the response (or a forced timeout fault) back to the
// owner only.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-requester read request            [NREQ]
//   req_addr        per-requester word address, slice i = [32*i +: 32]
//   req_gnt         one-hot accept pulse (combinational, IDLE)
//   resp_valid      one-hot response pulse to the owner (combinational, WAIT)
//   resp_rdata      response data, zero when no resp_valid
//   resp_fault      response fault, zero when no resp_valid
//   mem_req         bus request pulse (ISSUE)
//   mem_addr        word-aligned bus address, zero outside ISSUE
//   mem_rvalid      bus response valid
//   mem_rdata       bus response data
//   mem_fault       bus response fault
//   busy            transaction outstanding
//   err_timeout     sticky: a bus timeout occurred
//   err_spurious    sticky: mem_rvalid seen outside WAIT
//   err_clr         clears both sticky bits (a same-cycle set wins)

module imem_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]      req_gnt,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_fault,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_fault,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_spurious,
    input  logic                 err_clr
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam bit          FP    = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_spurious_q, err_spurious_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [31:0]        addr_sel;
    logic               set_timeout;
    logic               set_spurious;

    // Winner pick: requester 0 first when fixed-priority, otherwise a
    // rotating search starting just after the last winner.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (FP && req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            // In fixed-priority mode requester 0 is excluded from the rotation.
            if (!win_found && req_valid[cand_idx] && !(FP && cand == 0)) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Address of the chosen requester.
    always_comb begin
        addr_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                addr_sel = req_addr[32*i +: 32];
            end
        end
    end

    // Next-state and outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        set_timeout   = 1'b0;
        set_spurious  = 1'b0;
        req_gnt       = '0;
        resp_valid    = '0;
        resp_rdata    = '0;
        resp_fault    = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        busy          = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                set_spurious = mem_rvalid;
                if (win_found) begin
                    req_gnt[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    addr_d           = {addr_sel[31:2], 2'b00};
                    last_d           = win_idx;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                set_spurious = mem_rvalid;
                mem_req      = 1'b1;
                mem_addr     = addr_q;
                cnt_d        = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real response beats a timeout landing in the same cycle.
                if (mem_rvalid) begin
                    resp_valid[owner_q] = 1'b1;
                    resp_rdata          = mem_rdata;
                    resp_fault          = mem_fault;
                    state_d             = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_valid[owner_q] = 1'b1;
                    resp_fault          = 1'b1;
                    set_timeout         = 1'b1;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing is visible while reset is held; an in-flight transaction
        // is simply dropped.
        if (rst) begin
            req_gnt      = '0;
            resp_valid   = '0;
            resp_rdata   = '0;
            resp_fault   = 1'b0;
            mem_req      = 1'b0;
            mem_addr     = '0;
            busy         = 1'b0;
            set_timeout  = 1'b0;
            set_spurious = 1'b0;
        end

        err_timeout_d  = (err_timeout_q  & ~err_clr) | set_timeout;
        err_spurious_d = (err_spurious_q & ~err_clr) | set_spurious;
    end

    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            owner_q        <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            last_q         <= IDX_W'(NREQ - 1);
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; expected grants, addresses, responses and
// sticky error bits come from a transaction-level model of the arbitration
// and bus-timing rules.

module tb_imem_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_addr;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               mem_fault;
    logic               err_clr;

    logic [NREQ-1:0]    req_gnt, resp_valid;
    logic [31:0]        resp_rdata, mem_addr;
    logic               resp_fault, mem_req, busy, err_timeout, err_spurious;

    logic [NREQ-1:0]    req_gnt_fp, resp_valid_fp;
    logic [31:0]        resp_rdata_fp, mem_addr_fp;
    logic               resp_fault_fp, mem_req_fp, busy_fp, err_timeout_fp, err_spurious_fp;

    imem_arbiter #(.NREQ(NREQ), .FIXED_PRIO(0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_gnt(req_gnt), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
        .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious),
        .err_clr(err_clr)
    );

    imem_arbiter #(.NREQ(NREQ), .FIXED_PRIO(1), .TIMEOUT(TIMEOUT)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_gnt(req_gnt_fp), .resp_valid(resp_valid_fp), .resp_rdata(resp_rdata_fp),
        .resp_fault(resp_fault_fp), .mem_req(mem_req_fp), .mem_addr(mem_addr_fp),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
        .busy(busy_fp), .err_timeout(err_timeout_fp), .err_spurious(err_spurious_fp),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [2:0]  pend;
    logic [31:0] addr_tab [NREQ];
    int          m_last, m_last_fp;
    bit          m_err_to, m_err_sp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_req();
        req_valid = pend;
        for (int r = 0; r < NREQ; r++) req_addr[32*r +: 32] = addr_tab[r];
    endtask

    // Arbitration rule: fixed mode takes requester 0 first; otherwise scan
    // upward from one past the last winner, wrapping modulo NREQ.
    function automatic int pick(input logic [2:0] p, input int last, input bit fixed);
        int c;
        if (fixed && p[0]) return 0;
        for (int s = 1; s <= NREQ; s++) begin
            c = (last + s) % NREQ;
            if (!(fixed && c == 0) && p[c[1:0]]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int w);
        logic [31:0] v;
        v = 32'd1 << w;
        return v;
    endfunction

    // delay: 1..TIMEOUT = memory answers in that WAIT cycle; 0 = never.
    task automatic do_txn(input int delay, input bit fault, input logic [31:0] rdata, input bit rearm);
        int w, wf, i;
        bit done;
        logic [31:0] exp_addr;
        w  = pick(pend, m_last, 1'b0);
        wf = pick(pend, m_last_fp, 1'b1);
        mem_rvalid = 1'b0;
        drive_req();
        settle();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("gnt", 32'(req_gnt), onehot(w));
        chk("gnt_fp", 32'(req_gnt_fp), onehot(wf));
        chk("err_timeout", 32'(err_timeout), 32'(m_err_to));
        chk("err_spurious", 32'(err_spurious), 32'(m_err_sp));
        tick();
        exp_addr  = {addr_tab[w][31:2], 2'b00};
        m_last    = w;
        m_last_fp = wf;
        pend[w]   = 1'b0;
        drive_req();
        mem_rdata = $urandom;
        mem_fault = 1'($urandom_range(0, 1));
        settle();
        chk("issue_mem_req", 32'(mem_req), 32'd1);
        chk("issue_mem_addr", mem_addr, exp_addr);
        chk("issue_gnt", 32'(req_gnt), 32'd0);
        chk("issue_resp", 32'(resp_valid), 32'd0);
        chk("issue_busy", 32'(busy), 32'd1);
        tick();
        i = 1;
        done = 1'b0;
        while (!done) begin
            if (i == delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                mem_fault  = fault;
            end else begin
                mem_rdata = $urandom;
                mem_fault = 1'($urandom_range(0, 1));
            end
            settle();
            if (i == delay) begin
                chk("resp_valid", 32'(resp_valid), onehot(w));
                chk("resp_rdata", resp_rdata, rdata);
                chk("resp_fault", 32'(resp_fault), 32'(fault));
                done = 1'b1;
            end else if (i == TIMEOUT) begin
                chk("to_resp_valid", 32'(resp_valid), onehot(w));
                chk("to_resp_rdata", resp_rdata, 32'd0);
                chk("to_resp_fault", 32'(resp_fault), 32'd1);
                m_err_to = 1'b1;
                done = 1'b1;
            end else begin
                chk("wait_resp", 32'(resp_valid), 32'd0);
                chk("wait_rdata", resp_rdata, 32'd0);
                chk("wait_fault", 32'(resp_fault), 32'd0);
                chk("wait_mem_req", 32'(mem_req), 32'd0);
                chk("wait_mem_addr", mem_addr, 32'd0);
                chk("wait_gnt", 32'(req_gnt), 32'd0);
            end
            tick();
            mem_rvalid = 1'b0;
            i++;
        end
        if (rearm) pend[w] = 1'b1;
    endtask

    // Reset with requests and a bus response present: nothing may escape.
    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 3'b111;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        mem_fault  = 1'b1;
        settle();
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        mem_fault  = 1'b0;
        pend       = '0;
        drive_req();
        settle();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_spur", 32'(err_spurious), 32'd0);
        chk("post_rst_to", 32'(err_timeout), 32'd0);
        chk("post_rst_resp", 32'(resp_valid), 32'd0);
        m_last    = NREQ - 1;
        m_last_fp = NREQ - 1;
        m_err_to  = 1'b0;
        m_err_sp  = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, d, w;
        rst = 1'b1; err_clr = 1'b0; pend = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_fault = 1'b0;
        for (int r = 0; r < NREQ; r++) addr_tab[r] = '0;
        drive_req();
        tick();
        do_reset();

        // Single request, 1-cycle memory.
        pend = 3'b001; addr_tab[0] = 32'h0000_1006;
        do_txn(1, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Fairness from reset: RR gives 0,1,2,0,1,2; fixed keeps picking 0.
        do_reset();
        pend = 3'b111;
        for (int r = 0; r < NREQ; r++) addr_tab[r] = $urandom;
        for (int n = 0; n < 6; n++) do_txn(1, 1'b0, $urandom, 1'b1);
        // Requester 0 quiet: fixed instance rotates among the others.
        pend = 3'b110;
        for (int n = 0; n < 4; n++) do_txn(1, 1'b0, $urandom, 1'b1);
        pend = '0;

        // Fault pass-through from requester 2.
        pend = 3'b100; addr_tab[2] = 32'h0000_2008;
        do_txn(2, 1'b1, 32'h0000_1234, 1'b0);

        // Timeout, sticky bit, clear, then a normal transaction.
        pend = 3'b010; addr_tab[1] = 32'h0000_300F;
        do_txn(0, 1'b0, 32'h0, 1'b0);
        drive_req();
        settle();
        chk("to_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err_to = 1'b0;
        settle();
        chk("to_cleared", 32'(err_timeout), 32'd0);
        tick();
        pend = 3'b010;
        do_txn(1, 1'b0, 32'h0BAD_F00D, 1'b0);

        // Spurious response in IDLE.
        pend = '0; drive_req();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; mem_fault = 1'b1;
        settle();
        chk("spur_resp", 32'(resp_valid), 32'd0);
        chk("spur_rdata", resp_rdata, 32'd0);
        chk("spur_fault", 32'(resp_fault), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("spur_sticky", 32'(err_spurious), 32'd1);
        // Clear and a new spurious event together: the set wins.
        mem_rvalid = 1'b1; err_clr = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("spur_set_wins", 32'(err_spurious), 32'd1);
        tick();
        err_clr = 1'b0;
        m_err_sp = 1'b0;
        settle();
        chk("spur_cleared", 32'(err_spurious), 32'd0);
        mem_fault = 1'b0;
        tick();

        // Response on the timeout cycle is a normal response.
        pend = 3'b001; addr_tab[0] = 32'h0000_4000;
        do_txn(TIMEOUT, 1'b0, 32'h7777_8888, 1'b0);
        drive_req();
        settle();
        chk("simul_no_to", 32'(err_timeout), 32'd0);
        tick();

        // Reset while waiting on the bus.
        pend = 3'b010; addr_tab[1] = 32'h0000_5000;
        w = pick(pend, m_last, 1'b0);
        drive_req();
        settle();
        chk("midrst_gnt", 32'(req_gnt), onehot(w));
        tick();
        pend = '0; drive_req();
        tick();
        tick();
        tick();
        settle();
        chk("midrst_busy_wait", 32'(busy), 32'd1);
        tick();
        do_reset();
        pend = 3'b111;
        for (int r = 0; r < NREQ; r++) addr_tab[r] = $urandom;
        do_txn(1, 1'b0, $urandom, 1'b0);
        pend = '0;

        // Randomized traffic.
        for (int n = 0; n < 25; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    addr_tab[r] = $urandom;
                end
            end
            if (pend == 3'b000) begin
                d = $urandom_range(0, NREQ - 1);
                pend[d] = 1'b1;
                addr_tab[d] = $urandom;
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      d = 0;
            else if (sel == 1) d = TIMEOUT;
            else               d = $urandom_range(1, 6);
            do_txn(d, 1'($urandom_range(0, 1)), $urandom, 1'b0);
        end
        pend = '0; drive_req();
        settle();
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_err_to", 32'(err_timeout), 32'(m_err_to));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single external instruction-memory bus between up to NREQ fetch-side requesters: icache refill, instruction prefetcher, debug/loader port.
- Accepts single-word read requests on a valid/grant handshake and issues exactly one bus transaction at a time.
- Routes the response (rdata/fault) back to the owning requester only.
- Enforces a bus timeout and reports protocol errors through sticky status bits.

Parameters:
NREQ, 3, number of requesters (2..8); index 0 = icache refill
FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins, others round-robin among themselves
TIMEOUT, 64, max cycles in WAIT before forced fault response (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester read request
req_addr  in  32*NREQ  per-requester word address, slice i = [32*i +: 32]
req_gnt  out  NREQ  one-hot accept pulse
resp_valid  out  NREQ  one-hot response pulse to owner
resp_rdata  out  32  response data, shared by all requesters
resp_fault  out  1  response fault, qualified by any resp_valid
mem_req  out  1  bus request pulse
mem_addr  out  32  bus address, word-aligned
mem_rvalid  in  1  bus response valid
mem_rdata  in  32  bus response data
mem_fault  in  1  bus response fault
busy  out  1  transaction outstanding (state != IDLE)
err_timeout  out  1  sticky: a timeout occurred
err_spurious  out  1  sticky: mem_rvalid seen outside WAIT
err_clr  in  1  clears both sticky bits

Behaviour:
- Reset is synchronous on posedge clk with rst=1.
  - State=IDLE, owner_q=0, addr_q=0, timeout counter=0, rr pointer last_q=NREQ-1, so requester 0 wins the first RR pick.
  - All outputs are 0 during and after reset.
  - A transaction in flight when rst asserts is abandoned; no resp_valid is produced for it.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid, choose winner w. RR searches from last_q+1 mod NREQ upward. With FIXED_PRIO=1, bit 0 wins if set.
  - req_gnt[w]=1 combinationally in the same cycle.
  - Register owner_q=w and addr_q={req_addr[w][31:2],2'b00}; update last_q=w; next state ISSUE.
  - No req_valid: stay in IDLE.
- Requester handshake: hold req_valid and req_addr stable until req_gnt is seen. Drop or re-arm valid the cycle after the grant. A requester may issue its next request only after its resp_valid.
- ISSUE: mem_req=1 and mem_addr=addr_q for exactly one cycle; counter=0; next state WAIT. mem_addr=0 in all other states.
- WAIT:
  - Counter increments each cycle.
  - If mem_rvalid: resp_valid[owner_q]=1, resp_rdata=mem_rdata, resp_fault=mem_fault, all combinational in the same cycle; next state IDLE.
  - Else if counter==TIMEOUT-1: resp_valid[owner_q]=1, resp_fault=1, resp_rdata=0; set err_timeout; next state IDLE.
  - mem_rvalid arriving in the same cycle as the timeout wins: it produces a normal response and does not set err_timeout.
- Minimum latency: request at cycle T → grant at T, mem_req at T+1, resp at T+2 if memory answers in the following cycle.
- Back-to-back: the cycle after a response the arbiter is in IDLE and may grant again. Maximum throughput is 1 word per 3 cycles.
- resp_rdata and resp_fault are 0 whenever no resp_valid is asserted.
- A mem_rvalid in IDLE or ISSUE is ignored for routing and sets err_spurious.
- err_clr clears both sticky bits. If a set condition occurs in the same cycle as err_clr, the set wins.
- Starvation bound (RR mode): a continuously asserting requester is granted within NREQ grants.

Test Plan:
- Single request: req_valid=3'b001, addr=0x0000_1006, memory answers 1 cycle after mem_req with 0xDEADBEEF → gnt[0] at T, mem_req at T+1 with mem_addr=0x0000_1004, resp_valid=3'b001 with rdata=0xDEADBEEF at T+2.
- RR fairness: all three valid continuously, 1-cycle memory → grant order 0,1,2,0,1,2. Same stimulus with FIXED_PRIO=1 → grants to 0 only while it stays valid.
- Fault pass-through: requester 2 granted, memory returns mem_fault=1, rdata=0x1234 → resp_valid=3'b100, resp_fault=1, rdata=0x1234, err_timeout stays 0.
- Timeout: memory never answers, TIMEOUT=64 → resp_valid[owner] with resp_fault=1, rdata=0 exactly 64 cycles after ISSUE; err_timeout=1 until err_clr. Then a new request completes normally.
- Spurious/simultaneous: mem_rvalid pulsed in IDLE → err_spurious=1, no resp_valid. mem_rvalid on the timeout cycle → normal response, err_timeout=0.
- Reset mid-op: assert rst in WAIT, then memory answers → no resp_valid, busy=0, err_spurious=0 during reset. Next request is granted to requester 0 first.
